// File: rtl/sfifo_ctrl_pkg.sv
// sfifo_ctrl_pkg: shared helper for the synchronous FIFO pointer/flag controller.
// The flag vector packs {pfull, pempty, full, empty, fullm1, emptyp1, emptyp2}.
package sfifo_ctrl_pkg;

  localparam int unsigned FLAG_NBITS = 7;

  // Status flags for a given occupancy. Signed integer compares let
  // degenerate thresholds (e.g. PFULL_LVL <= 0 when DEPTH is tiny) resolve
  // to constant-true/false naturally.
  function automatic logic [FLAG_NBITS-1:0] calc_flags(
    input int cnt,
    input int depth,
    input int pfull_lvl,
    input int pempty_lvl
  );
    calc_flags = {cnt >= pfull_lvl,
                  cnt <= pempty_lvl,
                  cnt == depth,
                  cnt == 0,
                  cnt == depth - 1,
                  cnt == 1,
                  cnt == 2};
  endfunction

endpackage

// File: rtl/sfifo_ctrl.sv
// sfifo_ctrl: pointer, occupancy and registered-flag controller for a
// single-clock FIFO whose storage array lives in the wrapper.
// Optional simulation-only protocol/consistency checks: define SFIFO_CTRL_CHECK_EN.
module sfifo_ctrl
  import sfifo_ctrl_pkg::*;
#(
  parameter int DEPTH_NBITS = 3,
  parameter int DEPTH       = 8,
  parameter int PFULL_LVL   = DEPTH - 2,
  parameter int PEMPTY_LVL  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd,
  input  logic                   wr,
  output logic                   pfull,
  output logic                   pempty,
  output logic [DEPTH_NBITS:0]   ncount,
  output logic [DEPTH_NBITS:0]   count,
  output logic                   full,
  output logic                   empty,
  output logic                   fullm1,
  output logic                   emptyp1,
  output logic                   emptyp2,
  output logic [DEPTH_NBITS-1:0] nrptr,
  output logic [DEPTH_NBITS-1:0] rptr,
  output logic [DEPTH_NBITS-1:0] wptr
);

  localparam int CW = DEPTH_NBITS + 1;

  logic                   rd_ok;
  logic                   wr_ok;
  logic [DEPTH_NBITS-1:0] nwptr;
  logic [FLAG_NBITS-1:0]  nflags;
  logic [FLAG_NBITS-1:0]  flags;

  // Qualified strobes and next-state values; flags derive from ncount so
  // the registered flags always agree with the registered count.
  always_comb begin
    rd_ok  = rd & ~empty;
    wr_ok  = wr & ~full;
    ncount = count + CW'(wr_ok) - CW'(rd_ok);
    nrptr  = rptr + DEPTH_NBITS'(rd_ok);
    nwptr  = wptr + DEPTH_NBITS'(wr_ok);
    nflags = calc_flags(int'(ncount), DEPTH, PFULL_LVL, PEMPTY_LVL);
  end

  // State registers; reset flags take whatever the compares give at count=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      flags <= calc_flags(0, DEPTH, PFULL_LVL, PEMPTY_LVL);
    end else begin
      count <= ncount;
      rptr  <= nrptr;
      wptr  <= nwptr;
      flags <= nflags;
    end
  end

  assign {pfull, pempty, full, empty, fullm1, emptyp1, emptyp2} = flags;

`ifdef SFIFO_CTRL_CHECK_EN
  // Simulation-only misuse and internal consistency reporting.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (rd && empty)
        $display("ERROR: %0t %m read when FIFO empty", $time);
      if (wr && full)
        $display("ERROR: %0t %m write when FIFO full", $time);
      if (int'(count) > DEPTH)
        $display("ERROR: %0t %m count %0d exceeds depth %0d", $time, count, DEPTH);
      if (flags != calc_flags(int'(count), DEPTH, PFULL_LVL, PEMPTY_LVL))
        $display("ERROR: %0t %m flags %b inconsistent with count %0d", $time, flags, count);
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_ctrl.sv
// tb_sfifo_ctrl: directed scoreboard bench for sfifo_ctrl with
// DEPTH_NBITS=3, DEPTH=7, PFULL_LVL=5, PEMPTY_LVL=1.
module tb_sfifo_ctrl;

  localparam int D  = 7;

  typedef struct packed {
    logic [3:0] cnt;
    logic [2:0] rp;
    logic [2:0] wp;
    logic [6:0] fl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd  = 1'b0;
  logic       wr  = 1'b0;
  logic       pfull, pempty, full, empty, fullm1, emptyp1, emptyp2;
  logic [3:0] ncount, count;
  logic [2:0] nrptr, rptr, wptr;

  int   vectors     = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  logic [3:0] m_count = '0;
  logic [2:0] m_rptr  = '0;
  logic [2:0] m_wptr  = '0;

  sfifo_ctrl #(
    .DEPTH_NBITS(3),
    .DEPTH      (7),
    .PFULL_LVL  (5),
    .PEMPTY_LVL (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .rd     (rd),
    .wr     (wr),
    .pfull  (pfull),
    .pempty (pempty),
    .ncount (ncount),
    .count  (count),
    .full   (full),
    .empty  (empty),
    .fullm1 (fullm1),
    .emptyp1(emptyp1),
    .emptyp2(emptyp2),
    .nrptr  (nrptr),
    .rptr   (rptr),
    .wptr   (wptr)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected flags {pfull, pempty, full, empty, fullm1, emptyp1, emptyp2}.
  function automatic logic [6:0] exp_flags(input logic [3:0] c);
    exp_flags = {c >= 4'd5, c <= 4'd1, c == 4'd7, c == 4'd0,
                 c == 4'd6, c == 4'd1, c == 4'd2};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock of stimulus: drive at negedge, check combinational outputs,
  // push the predicted registered state, then pop and compare after posedge.
  task automatic step(input logic r, input logic w, input logic rs);
    exp_t       e;
    exp_t       got;
    logic       rok, wok;
    logic [3:0] nc;
    logic [2:0] nr, nw;
    @(negedge clk);
    rd  = r;
    wr  = w;
    rst = rs;
    #1;
    rok = r && (m_count != 4'd0);
    wok = w && (m_count != 4'(D));
    if (rs) begin
      nc = '0;
      nr = '0;
      nw = '0;
    end else begin
      nc = m_count + 4'(wok) - 4'(rok);
      nr = m_rptr + 3'(rok);
      nw = m_wptr + 3'(wok);
      chk("ncount", 8'(ncount), 8'(nc));
      chk("nrptr", 8'(nrptr), 8'(nr));
    end
    e.cnt = nc;
    e.rp  = nr;
    e.wp  = nw;
    e.fl  = exp_flags(nc);
    exp_q.push_back(e);
    m_count = nc;
    m_rptr  = nr;
    m_wptr  = nw;
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    chk("count", 8'(count), 8'(got.cnt));
    chk("rptr", 8'(rptr), 8'(got.rp));
    chk("wptr", 8'(wptr), 8'(got.wp));
    chk("flags", 8'({pfull, pempty, full, empty, fullm1, emptyp1, emptyp2}), 8'(got.fl));
  endtask

  initial begin
    // Reset held two cycles, then an idle cycle to observe ncount at rest.
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);

    // Fill to capacity, then a write while full.
    for (int unsigned i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);

    // Drain, then a read while empty.
    for (int unsigned i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Alternating write/read pairs drive both pointers through the wrap.
    for (int unsigned i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0);
    end

    // Simultaneous rd&wr at count 3, 0 and 7.
    for (int unsigned i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    for (int unsigned i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Mid-operation reset at count 4, then resume.
    for (int unsigned i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    chk("queue_drained", 8'(exp_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sfifo_ctrl.md
Name: sfifo_ctrl

Overview:
- Pointer, occupancy and flag controller for a synchronous single-clock FIFO. The storage array is external.
- Wrapper FIFOs instantiate it next to their storage array. They drive the qualified rd/wr strobes and use wptr/rptr to address the array.
- It provides the current and next occupancy, the next read pointer, and registered status flags (full, empty, near-full, near-empty, programmable thresholds).

Parameters:
- DEPTH_NBITS, 3, pointer width. The ring has 2^DEPTH_NBITS slots.
- DEPTH, 8, usable capacity in entries. Legal range is 1..2^DEPTH_NBITS; wrappers commonly pass (2^DEPTH_NBITS)-1.
- PFULL_LVL, DEPTH-2, pfull asserts when count >= PFULL_LVL.
- PEMPTY_LVL, 1, pempty asserts when count <= PEMPTY_LVL.

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset. This is the codebase `RESET_SIG port.
- rd  in  1  read/pop request for this cycle.
- wr  in  1  write/push request for this cycle.
- pfull  out  1  registered; count >= PFULL_LVL.
- pempty  out  1  registered; count <= PEMPTY_LVL.
- ncount  out  DEPTH_NBITS+1  combinational next-cycle occupancy.
- count  out  DEPTH_NBITS+1  registered occupancy.
- full  out  1  registered; count == DEPTH.
- empty  out  1  registered; count == 0.
- fullm1  out  1  registered; count == DEPTH-1.
- emptyp1  out  1  registered; count == 1.
- emptyp2  out  1  registered; count == 2.
- nrptr  out  DEPTH_NBITS  combinational next read pointer.
- rptr  out  DEPTH_NBITS  registered read pointer (slot holding the head entry).
- wptr  out  DEPTH_NBITS  registered write pointer (slot the next write goes to).

Behaviour:
- Reset (sync, rst=1 at posedge):
  - count, rptr and wptr go to 0.
  - empty=1; pempty=1 (requires PEMPTY_LVL >= 0).
  - full, fullm1, emptyp1, emptyp2 and pfull go to 0. Exception: each flag takes the value its compare gives at count=0, e.g. fullm1=1 when DEPTH=1.
  - Reset mid-operation discards all contents; the reset state is visible in the following cycle.
- Qualified strobes:
  - rd_ok = rd & ~empty.
  - wr_ok = wr & ~full.
  - A write while full is ignored, even when rd is also asserted.
  - A read while empty is ignored.
- Next-state values:
  - ncount = count + wr_ok - rd_ok, computed at DEPTH_NBITS+1 bits. It never exceeds DEPTH and never goes below 0.
  - nrptr = rptr + rd_ok, modulo 2^DEPTH_NBITS.
  - nwptr = wptr + wr_ok, modulo 2^DEPTH_NBITS.
  - Pointers wrap naturally; when DEPTH < 2^DEPTH_NBITS the ring still cycles through all slots.
- Simultaneous rd&wr with 0<count<DEPTH: both pointers advance and count is unchanged.
- Registers load ncount, nrptr and nwptr each clock.
- All flags are registered and computed from ncount, so they are consistent with count in the same cycle. They have zero extra latency relative to count.
- A write in cycle N gives count/empty updated in cycle N+1. The storage slot written is wptr in cycle N.
- The read head is always at rptr, so data is readable combinationally at array[rptr].
- ncount and nrptr are combinational from rd, wr and the registers. There are no combinational paths between other outputs.

Optional Feature:
- Macro SFIFO_CTRL_CHECK_EN.
- When defined, simulation-only checks run at each posedge with rst=0:
  - rd&empty prints "ERROR: <time> <hier> read when FIFO empty".
  - wr&full prints "ERROR: <time> <hier> write when FIFO full".
  - Also reported: count > DEPTH, or the flags inconsistent with count.
- When undefined, no checks exist. RTL function is identical either way.

Decomposition:
- No new typedefs. Reset/clock macros come from the shared defines.vh.
- Single flat module with no sub-modules. The wrapper FIFOs own storage and data typing.

Test Plan:
- Reset: assert rst 2 cycles -> count=0, empty=1, pempty=1, full=0, rptr=wptr=0, ncount=0.
- Fill (DEPTH_NBITS=3, DEPTH=7):
  - 7 writes -> count steps 1..7; emptyp1 at 1, emptyp2 at 2, fullm1 at 6, full at 7; pfull from count 5; wptr=7.
  - An 8th wr while full -> count stays 7, wptr stays 7.
- Drain: 7 reads -> rptr 0..7, count to 0, empty=1. A further rd -> rptr and count unchanged; nrptr==rptr.
- Wrap: 20 alternating write/read pairs -> wptr and rptr wrap 7->0; count toggles 1/0; nrptr = rptr+1 mod 8 during reads.
- Simultaneous rd&wr:
  - At count=3 -> count stays 3, both pointers advance.
  - At count=0 -> write only, count becomes 1.
  - At count=7 -> read only, count becomes 6.
- Mid-operation reset at count=4 -> next cycle count=0, empty=1, pointers 0. Normal operation resumes afterwards.
